// File: rtl/sum_deskew_collector_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg: shared constants and types for the systolic-array collector slice.
//   SUM_W  : default bits per partial-sum lane
//   ACT_W  : activation width used by the array feeders
//   coll_state_e : collector FSM states
// ---------------------------------------------------------------------------
package sa_pkg;

  localparam int SUM_W = 16;
  localparam int ACT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } coll_state_e;

endpackage

// File: rtl/sum_deskew_collector_if.sv
// ---------------------------------------------------------------------------
// sum_deskew_collector_if: array-bottom sum bus plus the aligned-row stream.
//   sum_vld / sum_in       : skewed partial sums from the PE array
//   out_data / out_valid   : aligned rows towards writeback
//   out_ready              : writeback back-pressure
// modport slave  : the collector side
// modport master : the side that drives sums and consumes rows
// ---------------------------------------------------------------------------
interface sum_deskew_collector_if #(
  parameter int NUM_COL = 16,
  parameter int SUM_W   = 16
);

  logic                     sum_vld;
  logic [NUM_COL*SUM_W-1:0] sum_in;
  logic [NUM_COL*SUM_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport slave (
    input  sum_vld,
    input  sum_in,
    input  out_ready,
    output out_data,
    output out_valid
  );

  modport master (
    output sum_vld,
    output sum_in,
    output out_ready,
    input  out_data,
    input  out_valid
  );

endinterface

// File: rtl/sum_deskew_collector_fifo.sv
// ---------------------------------------------------------------------------
// sum_row_fifo: synchronous row FIFO with a registered head register.
//   CLK, RESET : clock, synchronous active-high reset
//   wr_en/wr_data : push request (accepted when not full or when popping)
//   rd_ready   : consumer accepts the head when rd_valid
//   rd_data    : registered head row; holds its last value while empty
//   rd_valid   : FIFO not empty
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sum_row_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] rd_data_reg;
  logic             push, pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign pop      = !empty && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still push.
  assign push     = wr_en && (!full || pop);
  assign rd_valid = !empty;
  assign rd_data  = rd_data_reg;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      // Preload the head register with whatever will sit at the new read
      // pointer. When that slot is the one being written this edge, the
      // incoming row is forwarded so an empty FIFO shows it one cycle later.
      if (count_next != '0) begin
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
          rd_data_reg <= wr_data;
        end else begin
          rd_data_reg <= mem[rd_ptr_next];
        end
      end
    end
  end

endmodule

// File: rtl/sum_deskew_collector.sv
// ---------------------------------------------------------------------------
// sum_deskew_collector: re-aligns the diagonally skewed partial-sum bus from
// the bottom of the PE array (column j lags column 0 by j cycles), buffers
// aligned rows in a small FIFO and streams them to writeback. Counts rows per
// tile and pulses done at tile completion.
//   CLK, RESET : clock, synchronous active-high reset (aborts a tile)
//   start      : begin a tile of m_rows rows (ignored while busy)
//   m_rows     : rows in the tile, sampled when start is accepted
//   bus        : sum_vld/sum_in in, out_data/out_valid/out_ready stream
//   busy       : FSM not idle
//   done       : one-cycle pulse when the tile has fully drained
//   overflow   : sticky, set when an aligned row was dropped on a full FIFO
// Build option: define SUM_DESKEW_RELU_EN to clamp negative lanes to zero on
// the FIFO write path (no added latency). NUM_COL must be at least 2.
// ---------------------------------------------------------------------------
module sum_deskew_collector
  import sa_pkg::*;
#(
  parameter int NUM_COL    = 16,
  parameter int SUM_W      = sa_pkg::SUM_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [CNT_W-1:0] m_rows,
  sum_deskew_collector_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int ROW_W = NUM_COL * SUM_W;

  coll_state_e      state_reg, state_next;
  logic [CNT_W-1:0] m_rows_reg;
  logic [CNT_W-1:0] row_cnt_reg;
  logic             overflow_reg;
  logic [NUM_COL-2:0] vld_pipe_reg;
  logic             capture_vld;
  logic             wr_en;
  logic [ROW_W-1:0] aligned_row;
  logic [ROW_W-1:0] wr_row;
  logic             fifo_full, fifo_empty;

  // Only sums that enter while capturing are tracked; the pipe itself keeps
  // draining after the FSM leaves CAPTURE.
  assign capture_vld = bus.sum_vld && (state_reg == CAPTURE);
  assign wr_en       = vld_pipe_reg[NUM_COL-2];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_pipe_reg <= '0;
    end else begin
      vld_pipe_reg[0] <= capture_vld;
      for (int k = 1; k < NUM_COL - 1; k++) begin
        vld_pipe_reg[k] <= vld_pipe_reg[k-1];
      end
    end
  end

  // Lane j arrives j cycles after lane 0, so it is delayed NUM_COL-1-j
  // registers; all lanes then line up with the tail of the valid pipe.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COL; gi++) begin : g_skew
      localparam int DLY = NUM_COL - 1 - gi;
      logic [SUM_W-1:0] lane_in;
      assign lane_in = bus.sum_in[gi*SUM_W +: SUM_W];

      if (DLY == 0) begin : g_direct
        assign aligned_row[gi*SUM_W +: SUM_W] = lane_in;
      end else begin : g_pipe
        logic [SUM_W-1:0] pipe_reg [DLY];
        always_ff @(posedge CLK) begin
          if (RESET) begin
            for (int k = 0; k < DLY; k++) begin
              pipe_reg[k] <= '0;
            end
          end else begin
            pipe_reg[0] <= lane_in;
            for (int k = 1; k < DLY; k++) begin
              pipe_reg[k] <= pipe_reg[k-1];
            end
          end
        end
        assign aligned_row[gi*SUM_W +: SUM_W] = pipe_reg[DLY-1];
      end
    end
  endgenerate

`ifdef SUM_DESKEW_RELU_EN
  generate
    for (gi = 0; gi < NUM_COL; gi++) begin : g_relu
      assign wr_row[gi*SUM_W +: SUM_W] = aligned_row[gi*SUM_W + SUM_W - 1] ?
                                         '0 : aligned_row[gi*SUM_W +: SUM_W];
    end
  endgenerate
`else
  assign wr_row = aligned_row;
`endif

  sum_row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .wr_en    (wr_en),
    .wr_data  (wr_row),
    .rd_ready (bus.out_ready),
    .rd_data  (bus.out_data),
    .rd_valid (bus.out_valid),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (m_rows_reg == '0) begin
          state_next = DONE;
        end else if (row_cnt_reg == m_rows_reg) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= IDLE;
      m_rows_reg   <= '0;
      row_cnt_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && start) begin
        m_rows_reg  <= m_rows;
        row_cnt_reg <= '0;
      end else if ((state_reg == CAPTURE) && wr_en && (row_cnt_reg != m_rows_reg)) begin
        // Dropped rows still count toward the tile.
        row_cnt_reg <= row_cnt_reg + 1'b1;
      end
      if (wr_en && fifo_full && !(bus.out_valid && bus.out_ready)) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign overflow = overflow_reg;

endmodule
